// File: rtl/pixel_map_scheduler.sv
// rtl/pixel_map_scheduler.sv - frame sequencer: coefficient commit, raster walk, mapper handshake, frame-buffer writes
module pixel_map_scheduler #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int MAX_WAIT = 63
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_start,
    input  logic               coef_load,
    input  logic signed [25:0] c1_in,
    input  logic signed [25:0] c2_in,
    input  logic signed [27:0] c3_in,
    input  logic signed [24:0] c4_in,
    input  logic signed [24:0] c5_in,
    input  logic signed [26:0] c6_in,
    input  logic signed [17:0] c7_in,
    input  logic signed [17:0] c8_in,
    input  logic signed [19:0] c9_in,
    output logic signed [25:0] p1,
    output logic signed [25:0] p2,
    output logic signed [27:0] p3,
    output logic signed [24:0] p4,
    output logic signed [24:0] p5,
    output logic signed [26:0] p6,
    output logic signed [17:0] p7,
    output logic signed [17:0] p8,
    output logic signed [19:0] p9,
    output logic [9:0]         map_x,
    output logic [8:0]         map_y,
    output logic               map_start,
    input  logic               map_ready,
    input  logic [9:0]         map_ox,
    input  logic [8:0]         map_oy,
    input  logic               map_neg,
    output logic               wr_en,
    output logic [18:0]        wr_addr,
    output logic [9:0]         wr_src_x,
    output logic [8:0]         wr_src_y,
    input  logic               wr_ready,
    output logic               busy,
    output logic               frame_done,
    output logic [18:0]        skip_count,
    output logic               timeout_err
);

    localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);
    localparam logic [9:0]    X_LAST   = 10'(H_ACTIVE - 1);
    localparam logic [8:0]    Y_LAST   = 9'(V_ACTIVE - 1);
    localparam logic [18:0]   H_W      = 19'(H_ACTIVE);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, NEXT} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WW-1:0]   wait_cnt;
    logic signed [25:0] s1, s2;
    logic signed [27:0] s3;
    logic signed [24:0] s4, s5;
    logic signed [26:0] s6;
    logic signed [17:0] s7, s8;
    logic signed [19:0] s9;

    logic accept, out_of_range, timed_out, last_col, last_row, skip_inc;

    assign accept       = (state == IDLE) && frame_start;
    assign out_of_range = map_neg || (map_ox > X_LAST) || (map_oy > Y_LAST);
    assign timed_out    = !map_ready && (wait_cnt == WAIT_LIM);
    assign last_col     = (map_x == X_LAST);
    assign last_row     = (map_y == Y_LAST);
    assign skip_inc     = (state == WAIT) && ((map_ready && out_of_range) || timed_out);
    assign wr_src_x     = map_x;
    assign wr_src_y     = map_y;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (frame_start) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (map_ready)      state_nxt = out_of_range ? NEXT : WRITE;
                else if (timed_out) state_nxt = NEXT;
            end
            WRITE: if (wr_ready) state_nxt = NEXT;
            NEXT:  state_nxt = (last_col && last_row) ? IDLE : ISSUE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        map_start = (state == ISSUE);
        wr_en     = (state == WRITE);
        busy      = (state != IDLE);
    end

    // Shadow bank takes loads any time; active bank changes only on an accepted frame start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '0; s2 <= '0; s3 <= '0; s4 <= '0; s5 <= '0;
            s6 <= '0; s7 <= '0; s8 <= '0; s9 <= '0;
            p1 <= '0; p2 <= '0; p3 <= '0; p4 <= '0; p5 <= '0;
            p6 <= '0; p7 <= '0; p8 <= '0; p9 <= '0;
        end else begin
            if (coef_load) begin
                s1 <= c1_in; s2 <= c2_in; s3 <= c3_in; s4 <= c4_in; s5 <= c5_in;
                s6 <= c6_in; s7 <= c7_in; s8 <= c8_in; s9 <= c9_in;
            end
            if (accept) begin
                p1 <= coef_load ? c1_in : s1;
                p2 <= coef_load ? c2_in : s2;
                p3 <= coef_load ? c3_in : s3;
                p4 <= coef_load ? c4_in : s4;
                p5 <= coef_load ? c5_in : s5;
                p6 <= coef_load ? c6_in : s6;
                p7 <= coef_load ? c7_in : s7;
                p8 <= coef_load ? c8_in : s8;
                p9 <= coef_load ? c9_in : s9;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            map_x       <= '0;
            map_y       <= '0;
            wait_cnt    <= '0;
            wr_addr     <= '0;
            skip_count  <= '0;
            timeout_err <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= (state == NEXT) && last_col && last_row;
            if (accept) begin
                map_x       <= '0;
                map_y       <= '0;
                skip_count  <= '0;
                timeout_err <= 1'b0;
            end else begin
                if (skip_inc && (skip_count != '1)) skip_count <= skip_count + 19'd1;
                if ((state == WAIT) && timed_out)   timeout_err <= 1'b1;
            end
            if (state == ISSUE)                 wait_cnt <= '0;
            else if ((state == WAIT) && !map_ready) wait_cnt <= wait_cnt + 1'b1;
            if ((state == WAIT) && map_ready)
                wr_addr <= {10'd0, map_oy} * H_W + {9'd0, map_ox};
            if ((state == NEXT) && !(last_col && last_row)) begin
                if (last_col) begin
                    map_x <= '0;
                    map_y <= map_y + 9'd1;
                end else begin
                    map_x <= map_x + 10'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_map_scheduler.sv
// tb/tb_pixel_map_scheduler.sv - directed bench for pixel_map_scheduler on an 8x4 frame
module tb_pixel_map_scheduler;

    localparam int H = 8;
    localparam int V = 4;
    localparam int NPIX = H * V;

    logic clk, reset_n, frame_start, coef_load;
    logic signed [25:0] c1_in, c2_in;
    logic signed [27:0] c3_in;
    logic signed [24:0] c4_in, c5_in;
    logic signed [26:0] c6_in;
    logic signed [17:0] c7_in, c8_in;
    logic signed [19:0] c9_in;
    logic signed [25:0] p1, p2;
    logic signed [27:0] p3;
    logic signed [24:0] p4, p5;
    logic signed [26:0] p6;
    logic signed [17:0] p7, p8;
    logic signed [19:0] p9;
    logic [9:0]  map_x, map_ox, wr_src_x;
    logic [8:0]  map_y, map_oy, wr_src_y;
    logic        map_start, map_ready, map_neg, wr_en, wr_ready, busy, frame_done, timeout_err;
    logic [18:0] wr_addr, skip_count;

    pixel_map_scheduler #(.H_ACTIVE(H), .V_ACTIVE(V), .MAX_WAIT(63)) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .coef_load(coef_load),
        .c1_in(c1_in), .c2_in(c2_in), .c3_in(c3_in), .c4_in(c4_in), .c5_in(c5_in),
        .c6_in(c6_in), .c7_in(c7_in), .c8_in(c8_in), .c9_in(c9_in),
        .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8), .p9(p9),
        .map_x(map_x), .map_y(map_y), .map_start(map_start), .map_ready(map_ready),
        .map_ox(map_ox), .map_oy(map_oy), .map_neg(map_neg),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_src_x(wr_src_x), .wr_src_y(wr_src_y),
        .wr_ready(wr_ready), .busy(busy), .frame_done(frame_done),
        .skip_count(skip_count), .timeout_err(timeout_err)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int lat = 4;
    int mode = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    int wa_q[$], wx_q[$], wy_q[$];
    int sx_q[$], sy_q[$], sc_q[$];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Mapper model: answers lat cycles after map_start, per the current mode.
    initial begin
        bit pend;
        int cnt;
        logic [9:0] px;
        logic [8:0] py;
        pend = 0; cnt = 0; px = 0; py = 0;
        map_ready = 0; map_ox = 0; map_oy = 0; map_neg = 0;
        forever begin
            @(negedge clk);
            map_ready = 0;
            if (!reset_n) pend = 0;
            else begin
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        pend = 0;
                        map_ready = 1;
                        map_ox = (mode == 1 && px < 2) ? 10'd700 : px;
                        map_oy = py;
                        map_neg = (mode == 1 && py == 9'(V - 1));
                    end
                end
                if (map_start && !(mode == 2 && map_x == 10'd5 && map_y == 9'd0)) begin
                    pend = 1; cnt = lat; px = map_x; py = map_y;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset_n) begin
                if (wr_en && wr_ready) begin
                    wa_q.push_back(int'(wr_addr));
                    wx_q.push_back(int'(wr_src_x));
                    wy_q.push_back(int'(wr_src_y));
                end
                if (frame_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (map_start) begin
                    sx_q.push_back(int'(map_x));
                    sy_q.push_back(int'(map_y));
                    sc_q.push_back(cyc);
                end
            end
        end
    end

    task automatic clear_logs();
        wa_q.delete(); wx_q.delete(); wy_q.delete();
        sx_q.delete(); sy_q.delete(); sc_q.delete();
    endtask

    task automatic start_frame();
        @(negedge clk);
        frame_start = 1;
        @(negedge clk);
        frame_start = 0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (done_cnt != d0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_start(input int x, input int y, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (map_start && map_x == 10'(x) && map_y == 9'(y)) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 0;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, map_start, wr_en, frame_done, timeout_err} !== 5'b0 || skip_count !== 19'd0 ||
            wr_addr !== 19'd0 || map_x !== 10'd0 || map_y !== 9'd0) begin
            fails++;
            $display("FAIL reset_ctrl: busy=%0b ms=%0b we=%0b fd=%0b te=%0b skip=%0d addr=%0d x=%0d y=%0d, all zero required",
                     busy, map_start, wr_en, frame_done, timeout_err, skip_count, wr_addr, map_x, map_y);
        end
        tests++;
        if (p1 !== 0 || p2 !== 0 || p3 !== 0 || p4 !== 0 || p5 !== 0 ||
            p6 !== 0 || p7 !== 0 || p8 !== 0 || p9 !== 0) begin
            fails++;
            $display("FAIL reset_coef: p1=%0d p9=%0d, zero required", p1, p9);
        end
        reset_n = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_identity();
        bit ok;
        int d0, bad;
        mode = 0; lat = 4; clear_logs();
        d0 = done_cnt;
        start_frame();
        tests++;
        if (map_start !== 1'b1 || map_x !== 10'd0 || map_y !== 9'd0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL first_issue: map_start=%0b x=%0d y=%0d busy=%0b, need 1/0/0/1", map_start, map_x, map_y, busy);
        end
        wait_done(d0, 400, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL identity_done_timeout: frame_done not seen"); end
        tests++;
        if (done_cyc - start_cyc !== NPIX * 7) begin
            fails++;
            $display("FAIL identity_done_time: %0d cycles, need %0d", done_cyc - start_cyc, NPIX * 7);
        end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL busy_fall: busy=%0b with frame_done, need 0", busy); end
        repeat (5) @(negedge clk);
        tests++;
        if (done_cnt - d0 !== 1) begin fails++; $display("FAIL done_once: %0d pulses, need 1", done_cnt - d0); end
        tests++;
        if (wa_q.size() !== NPIX) begin fails++; $display("FAIL identity_writes: %0d writes, need %0d", wa_q.size(), NPIX); end
        bad = 0;
        for (int i = 0; i < wa_q.size(); i++)
            if (wa_q[i] != i || wx_q[i] != i % H || wy_q[i] != i / H) bad++;
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL raster_order: %0d wrong writes, need 0", bad); end
        tests++;
        if (skip_count !== 19'd0 || timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL identity_skip: skip=%0d te=%0b, need 0/0", skip_count, timeout_err);
        end
    endtask

    task automatic test_out_of_range();
        bit ok;
        int d0, bad;
        mode = 1; clear_logs();
        d0 = done_cnt;
        start_frame();
        wait_done(d0, 400, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL oor_done_timeout: frame_done not seen"); end
        tests++;
        if (skip_count !== 19'd14) begin fails++; $display("FAIL oor_skip: skip=%0d, need 14", skip_count); end
        tests++;
        if (wa_q.size() !== 18) begin fails++; $display("FAIL oor_writes: %0d writes, need 18", wa_q.size()); end
        bad = 0;
        for (int i = 0; i < wa_q.size(); i++)
            if (wx_q[i] < 2 || wy_q[i] == V - 1 || wa_q[i] != wy_q[i] * H + wx_q[i]) bad++;
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL oor_content: %0d bad writes, need 0", bad); end
        tests++;
        if (timeout_err !== 1'b0) begin fails++; $display("FAIL oor_te: te=%0b, need 0", timeout_err); end
    endtask

    task automatic test_timeout();
        bit ok;
        int d0, c5, c6;
        mode = 2; clear_logs();
        d0 = done_cnt;
        start_frame();
        wait_done(d0, 600, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL to_done_timeout: frame_done not seen"); end
        c5 = -1; c6 = -1;
        for (int i = 0; i < sc_q.size(); i++) begin
            if (sx_q[i] == 5 && sy_q[i] == 0) c5 = sc_q[i];
            if (sx_q[i] == 6 && sy_q[i] == 0) c6 = sc_q[i];
        end
        tests++;
        if (c5 < 0 || c6 - c5 !== 66) begin
            fails++;
            $display("FAIL to_gap: issue(5,0)->issue(6,0) %0d cycles, need 66", c6 - c5);
        end
        tests++;
        if (timeout_err !== 1'b1 || skip_count !== 19'd1) begin
            fails++;
            $display("FAIL to_flags: te=%0b skip=%0d, need 1/1", timeout_err, skip_count);
        end
        tests++;
        if (wa_q.size() !== NPIX - 1) begin fails++; $display("FAIL to_writes: %0d writes, need %0d", wa_q.size(), NPIX - 1); end
        mode = 0;
        d0 = done_cnt;
        start_frame();
        tests++;
        if (timeout_err !== 1'b0 || skip_count !== 19'd0) begin
            fails++;
            $display("FAIL to_clear: te=%0b skip=%0d after frame_start, need 0/0", timeout_err, skip_count);
        end
        wait_done(d0, 400, ok);
    endtask

    task automatic test_back_pressure();
        bit ok;
        int d0, bad, hits;
        mode = 0; clear_logs();
        d0 = done_cnt;
        start_frame();
        wait_start(3, 2, 400, ok);
        wr_ready = 0;
        tests++;
        if (!ok) begin fails++; $display("FAIL bp_reach: pixel (3,2) never issued"); end
        for (int i = 0; i < 20 && !wr_en; i++) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (wr_en !== 1'b1 || wr_addr !== 19'd19 || wr_src_x !== 10'd3 ||
                wr_src_y !== 9'd2 || map_x !== 10'd3) bad++;
            if (i < 19) @(negedge clk);
        end
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL bp_stable: %0d unstable cycles of 20, need 0 (addr=%0d)", bad, wr_addr); end
        wr_ready = 1;
        wait_done(d0, 400, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL bp_done_timeout: frame_done not seen"); end
        hits = 0;
        for (int i = 0; i < wa_q.size(); i++) if (wx_q[i] == 3 && wy_q[i] == 2) hits++;
        tests++;
        if (hits !== 1 || wa_q.size() !== NPIX) begin
            fails++;
            $display("FAIL bp_once: %0d writes of (3,2), %0d total, need 1 and %0d", hits, wa_q.size(), NPIX);
        end
    endtask

    task automatic test_coefficients();
        bit ok;
        int d0;
        d0 = done_cnt;
        start_frame();
        repeat (50) @(negedge clk);
        c1_in = 26'sd1000;
        coef_load = 1;
        @(negedge clk);
        coef_load = 0;
        repeat (3) @(negedge clk);
        tests++;
        if (p1 !== 26'sd0) begin fails++; $display("FAIL coef_midframe: p1=%0d, need 0", p1); end
        wait_done(d0, 400, ok);
        d0 = done_cnt;
        start_frame();
        tests++;
        if (p1 !== 26'sd1000 || p9 !== 20'sd0) begin
            fails++;
            $display("FAIL coef_commit: p1=%0d p9=%0d, need 1000/0", p1, p9);
        end
        wait_done(d0, 400, ok);
        d0 = done_cnt;
        @(negedge clk);
        c9_in = -20'sd5;
        coef_load = 1;
        frame_start = 1;
        @(negedge clk);
        coef_load = 0;
        frame_start = 0;
        tests++;
        if (map_start !== 1'b1 || p9 !== -20'sd5 || p1 !== 26'sd1000) begin
            fails++;
            $display("FAIL coef_bypass: ms=%0b p9=%0d p1=%0d, need 1/-5/1000", map_start, p9, p1);
        end
        wait_done(d0, 400, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL coef_done_timeout: frame_done not seen"); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int d0;
        d0 = done_cnt;
        start_frame();
        wait_start(5, 2, 400, ok);
        @(negedge clk);
        @(negedge clk);
        #1 reset_n = 0;
        #1;
        tests++;
        if ({busy, map_start, wr_en, frame_done} !== 4'b0 || map_x !== 10'd0 || map_y !== 9'd0 ||
            wr_addr !== 19'd0 || p1 !== 26'sd0 || p9 !== 20'sd0 || skip_count !== 19'd0) begin
            fails++;
            $display("FAIL midreset_zero: busy=%0b ms=%0b we=%0b x=%0d y=%0d p1=%0d, all zero required",
                     busy, map_start, wr_en, map_x, map_y, p1);
        end
        @(negedge clk);
        reset_n = 1;
        repeat (30) @(negedge clk);
        tests++;
        if (done_cnt !== d0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset_nodone: %0d frame_done pulses, busy=%0b, need 0/0", done_cnt - d0, busy);
        end
        start_frame();
        tests++;
        if (map_start !== 1'b1 || map_x !== 10'd0 || map_y !== 9'd0) begin
            fails++;
            $display("FAIL midreset_restart: ms=%0b x=%0d y=%0d, need 1/0/0", map_start, map_x, map_y);
        end
        wait_done(d0, 400, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL midreset_done_timeout: frame_done not seen"); end
    endtask

    initial begin
        reset_n = 0; frame_start = 0; coef_load = 0; wr_ready = 1;
        c1_in = 0; c2_in = 0; c3_in = 0; c4_in = 0; c5_in = 0;
        c6_in = 0; c7_in = 0; c8_in = 0; c9_in = 0;
        test_reset();
        test_identity();
        test_out_of_range();
        test_timeout();
        test_back_pressure();
        test_coefficients();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
